// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional macro MULDIV_EARLY_OUT_EN: zero operands, divide-by-zero and signed overflow skip the iterations.
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      md_op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);
    localparam int CNT_W = $clog2(ITER + 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_abs_q, b_abs_d;
    logic [2:0]          op_q, op_d;
    logic [4:0]          rd_q, rd_d;
    logic                sa_q, sa_d, sb_q, sb_d;
    logic                div0_q, div0_d, ovf_q, ovf_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [4:0]          rd_out_q, rd_out_d;

    logic                signed_a, signed_b, a_neg, b_neg, ovf_in, early;
    logic [XLEN-1:0]     a_abs, b_abs;
    logic [XLEN:0]       mul_sum, div_try;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quot_fix, rem_fix, fix_res;

    assign signed_a = (md_op == 3'b001) || (md_op == 3'b010) || (md_op == 3'b100) || (md_op == 3'b110);
    assign signed_b = (md_op == 3'b001) || (md_op == 3'b100) || (md_op == 3'b110);
    assign a_neg    = signed_a & operand_a[XLEN-1];
    assign b_neg    = signed_b & operand_b[XLEN-1];
    assign a_abs    = a_neg ? -operand_a : operand_a;
    assign b_abs    = b_neg ? -operand_b : operand_b;
    assign ovf_in   = signed_b && md_op[2] && (operand_a == INT_MIN) && (operand_b == '1);

`ifdef MULDIV_EARLY_OUT_EN
    assign early = (operand_a == '0) || (operand_b == '0) || ovf_in;
`else
    assign early = 1'b0;
`endif

    // Multiplier sits in the low half and shifts out; the partial product grows in the high half.
    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_abs_q} : '0);
    assign div_try = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_abs_q};

    assign prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
    assign quot_fix = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        fix_res = prod_fix[XLEN-1:0];
        case (op_q)
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = div0_q ? '1 : (ovf_q ? INT_MIN : quot_fix);
            3'b110, 3'b111:         fix_res = div0_q ? a_q : (ovf_q ? '0 : rem_fix);
            default:                fix_res = prod_fix[XLEN-1:0];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_abs_d  = b_abs_q;
        op_d     = op_q;
        rd_d     = rd_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = md_op;
                    rd_d    = rd_in;
                    sa_d    = a_neg;
                    sb_d    = b_neg;
                    a_d     = operand_a;
                    b_abs_d = b_abs;
                    div0_d  = md_op[2] && (operand_b == '0);
                    ovf_d   = ovf_in;
                    acc_d   = (early && !md_op[2]) ? '0 : {{XLEN{1'b0}}, a_abs};
                    cnt_d   = early ? '0 : CNT_W'(ITER);
                    state_d = CALC;
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (!op_q[2])
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    else if (div_try[XLEN])
                        acc_d = {acc_q[2*XLEN-2:0], 1'b0};
                    else
                        acc_d = {div_try[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                end
            end
            FIX: begin
                result_d = fix_res;
                rd_out_d = rd_q;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over everything, including a start in the same cycle and the FIX write.
        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
            rd_out_d = rd_out_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            b_abs_q  <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_abs_q  <= b_abs_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign busy   = (state_q == CALC) || (state_q == FIX);
    assign done   = (state_q == DONE) && !flush;
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, reference model, scoreboard and control corner cases.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n, start, flush;
    logic [2:0]  md_op;
    logic [31:0] operand_a, operand_b;
    logic [4:0]  rd_in;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .md_op(md_op),
        .operand_a(operand_a), .operand_b(operand_b), .rd_in(rd_in),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } sb_t;

    sb_t         exp_q[$];
    vec_t        vecs[20];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_res;
    logic [4:0]  last_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          pa, pb, ps;
        longint unsigned ua, ub, pu;
        int              ia, ib;
        logic            ovf;
        pa  = $signed(a);
        pb  = $signed(b);
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ia  = a;
        ib  = b;
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (op)
            3'd0: begin pu = ua * ub; return pu[31:0]; end
            3'd1: begin ps = pa * pb; return ps[63:32]; end
            3'd2: begin ps = pa * $signed(ub); return ps[63:32]; end
            3'd3: begin pu = ua * ub; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (ovf) return 32'h80000000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (a == 0 || b == 0) return 2;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
`endif
        return (op == 3'd7 && a == 32'hDEADBEEF && b == 32'hDEADBEEF) ? 34 : 34;
    endfunction

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic pop_cmp(input string name);
        sb_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard_empty actual=done expected=no_done", name);
        end else begin
            e = exp_q.pop_front();
            chk({name, " result"}, result, e.res);
            chk({name, " rd_out"}, {27'b0, rd_out}, {27'b0, e.rd});
            last_res = e.res;
            last_rd  = e.rd;
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input string name);
        int lat;
        @(negedge clk);
        start = 1'b1; md_op = op; operand_a = a; operand_b = b; rd_in = rd;
        exp_q.push_back('{exp, rd});
        @(posedge clk);
        #1;
        start = 1'b0; operand_a = $urandom; operand_b = $urandom; rd_in = 5'($urandom);
        chk({name, " busy_after_accept"}, {31'b0, busy}, 32'd1);
        wait_done(lat);
        chk({name, " latency"}, 32'(lat), 32'(exp_lat(op, a, b)));
        if (done) begin
            pop_cmp(name);
            chk({name, " busy_in_done"}, {31'b0, busy}, 32'd0);
            @(posedge clk);
            #1;
            chk({name, " done_one_cycle"}, {31'b0, done}, 32'd0);
        end
    endtask

    initial begin
        int lat;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        vecs[0]  = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'h00000000};
        vecs[2]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFF};
        vecs[3]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE};
        vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 5'd4,  32'hFFFFFFFD};
        vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 5'd6,  32'hFFFFFFFF};
        vecs[6]  = '{3'd5, 32'd100,      32'd7,        5'd7,  32'd14};
        vecs[7]  = '{3'd7, 32'd100,      32'd7,        5'd8,  32'd2};
        vecs[8]  = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd9,  32'h80000000};
        vecs[9]  = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h00000000};
        vecs[10] = '{3'd5, 32'd123,      32'd0,        5'd11, 32'hFFFFFFFF};
        vecs[11] = '{3'd7, 32'd123,      32'd0,        5'd12, 32'd123};
        vecs[12] = '{3'd4, 32'hFFFFFFEC, 32'd0,        5'd13, 32'hFFFFFFFF};
        vecs[13] = '{3'd6, 32'hFFFFFFEC, 32'd0,        5'd14, 32'hFFFFFFEC};
        vecs[14] = '{3'd0, 32'd0,        32'd5,        5'd15, 32'd0};
        vecs[15] = '{3'd1, 32'h80000000, 32'h80000000, 5'd16, 32'h40000000};
        vecs[16] = '{3'd0, 32'h12345678, 32'h00000010, 5'd17, 32'h23456780};
        vecs[17] = '{3'd6, 32'd7,        32'hFFFFFFFE, 5'd18, 32'd1};
        vecs[18] = '{3'd4, 32'd7,        32'hFFFFFFFE, 5'd19, 32'hFFFFFFFD};
        vecs[19] = '{3'd2, 32'h80000000, 32'd2,        5'd20, 32'hFFFFFFFF};

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; md_op = '0;
        operand_a = '0; operand_b = '0; rd_in = '0;
        last_res = '0; last_rd = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy",   {31'b0, busy}, 32'd0);
        chk("reset done",   {31'b0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset rd_out", {27'b0, rd_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++)
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, $sformatf("vec%0d", i));

        for (int i = 0; i < 16; i++) begin
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: ra = 32'h0;
                1: ra = 32'h80000000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: rb = 32'h0;
                1: rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            do_op(rop, ra, rb, 5'($urandom), ref_md(rop, ra, rb), $sformatf("rand%0d", i));
        end

        // Flush mid-divide: no done, outputs keep the previous result, next op runs normally.
        @(negedge clk);
        start = 1'b1; md_op = 3'd4; operand_a = 32'd1000; operand_b = 32'd3; rd_in = 5'd21;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush busy_low",  {31'b0, busy}, 32'd0);
        chk("flush done_low",  {31'b0, done}, 32'd0);
        chk("flush result_kept", result, last_res);
        chk("flush rd_kept",   {27'b0, rd_out}, {27'b0, last_rd});
        do_op(3'd5, 32'd1000, 32'd3, 5'd22, 32'd333, "after_flush");

        // Start and flush together in IDLE: nothing accepted.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; md_op = 3'd0; operand_a = 32'd3; operand_b = 32'd4; rd_in = 5'd23;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        chk("start_flush busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("start_flush busy2", {31'b0, busy}, 32'd0);
        chk("start_flush done",  {31'b0, done}, 32'd0);

        // Start held high: one accept per op, re-accept only in the cycle after done.
        @(negedge clk);
        start = 1'b1; md_op = 3'd5; operand_a = 32'd1000; operand_b = 32'd7; rd_in = 5'd24;
        exp_q.push_back('{32'd142, 5'd24});
        exp_q.push_back('{32'd142, 5'd24});
        @(posedge clk);
        #1;
        wait_done(lat);
        chk("held first latency", 32'(lat), 32'd34);
        if (done) pop_cmp("held first");
        @(posedge clk);
        #1;
        chk("held idle busy", {31'b0, busy}, 32'd0);
        chk("held idle done", {31'b0, done}, 32'd0);
        @(posedge clk);
        #1;
        chk("held reaccept busy", {31'b0, busy}, 32'd1);
        wait_done(lat);
        chk("held second latency", 32'(lat), 32'd34);
        start = 1'b0;
        if (done) pop_cmp("held second");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("held no_third busy", {31'b0, busy}, 32'd0);

        // Asynchronous reset in the middle of an iteration.
        @(negedge clk);
        start = 1'b1; md_op = 3'd0; operand_a = 32'd3; operand_b = 32'd5; rd_in = 5'd25;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset busy",   {31'b0, busy}, 32'd0);
        chk("midreset done",   {31'b0, done}, 32'd0);
        chk("midreset result", result, 32'd0);
        chk("midreset rd_out", {27'b0, rd_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) lat++;
        end
        chk("midreset no_activity", 32'(lat), 32'd0);
        do_op(3'd3, 32'h80000000, 32'd4, 5'd26, 32'd2, "after_reset");

        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
